// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared widths and accumulator state encoding for the approximate-multiplier datapath
package approx_mult_pkg;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} accum_state_t;
endpackage

// File: rtl/prod_accum_8x8.sv
// prod_accum_8x8: sums len unsigned 16-bit products into an ACC_W-bit wrapping result with sticky carry-out flag.
// Ports: clk, rst_n (sync, active-low); start/len begin a run in IDLE; in_valid/in_ready/in_prod product stream;
// out_valid/out_ready/out_sum/out_ovf registered result handshake; busy is high outside IDLE.
module prod_accum_8x8
  import approx_mult_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);
  accum_state_t     state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf;
  logic             hs;
  logic [ACC_W:0]   sum;
  assign hs  = in_valid && state == ACC;
  // one extra bit on top captures the carry out of the accumulator
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = len == '0 ? HOLD : ACC;
      ACC:     if (hs && cnt == LEN_W'(1)) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (hs) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt - LEN_W'(1);
      ovf <= ovf | sum[ACC_W];
    end
  end
  always_comb begin
    in_ready  = state == ACC;
    out_valid = state == HOLD;
    busy      = state != IDLE;
    out_sum   = acc;
    out_ovf   = ovf;
  end
endmodule

// File: tb/tb_prod_accum_8x8.sv
// tb_prod_accum_8x8: directed self-checking bench for prod_accum_8x8 (default width and 16-bit width instances)
module tb_prod_accum_8x8;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [7:0]  len = 0;
  logic        in_valid = 0;
  logic [15:0] in_prod = 0;
  logic        out_ready = 0;
  logic        in_ready, out_valid, out_ovf, busy;
  logic [23:0] out_sum;
  logic        in_ready16, out_valid16, out_ovf16, busy16;
  logic [15:0] out_sum16;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  prod_accum_8x8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );
  prod_accum_8x8 #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready16),
    .in_prod(in_prod), .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16), .out_ovf(out_ovf16), .busy(busy16)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    total++; if ({in_ready, out_valid, out_ovf, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {in_ready, out_valid, out_ovf, busy}); end
    total++; if (out_sum !== 24'd0) begin bad++; $display("FAIL reset_sum got=%0d want=0", out_sum); end
  endtask
  task automatic test_basic();
    start = 1; len = 3;
    step();
    start = 0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", in_ready); end
    in_valid = 1; in_prod = 100; step();
    in_prod = 200; step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
    in_prod = 300; step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_sum !== 24'd600 || out_ovf !== 1'b0) begin bad++; $display("FAIL basic_sum got=%0d/%b want=600/0", out_sum, out_ovf); end
    out_ready = 1; step(); out_ready = 0;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask
  task automatic test_overflow();
    start = 1; len = 2; step(); start = 0;
    in_valid = 1; in_prod = 16'hFFFF; step();
    in_prod = 16'h0002; step();
    in_valid = 0;
    total++; if (out_sum16 !== 16'h0001 || out_ovf16 !== 1'b1) begin bad++; $display("FAIL ovf16 got=%h/%b want=0001/1", out_sum16, out_ovf16); end
    total++; if (out_sum !== 24'h010001 || out_ovf !== 1'b0) begin bad++; $display("FAIL ovf24 got=%h/%b want=010001/0", out_sum, out_ovf); end
    out_ready = 1; step(); out_ready = 0;
  endtask
  task automatic test_stall();
    logic [6:0] pat;
    logic [15:0] p;
    pat = 7'b1011001;
    p = 1;
    start = 1; len = 4; step(); start = 0;
    for (int i = 0; i < 7; i++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=1", i, in_ready); end
      in_valid = pat[i]; in_prod = p;
      step();
      if (pat[i]) p++;
    end
    in_valid = 1; in_prod = 16'd50;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 24'd10) begin bad++; $display("FAIL stall_hold[%0d] got v=%b r=%b sum=%0d want 1/0/10", i, out_valid, in_ready, out_sum); end
      step();
    end
    in_valid = 0; out_ready = 1; step(); out_ready = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", busy); end
  endtask
  task automatic test_zero();
    start = 1; len = 0; step(); start = 0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL zero_flags got v=%b r=%b want 1/0", out_valid, in_ready); end
    total++; if (out_sum !== 24'd0 || out_ovf !== 1'b0) begin bad++; $display("FAIL zero_sum got=%0d/%b want=0/0", out_sum, out_ovf); end
    out_ready = 1; step(); out_ready = 0;
  endtask
  task automatic test_reset_mid();
    start = 1; len = 5; step(); start = 0;
    in_valid = 1; in_prod = 40; step();
    in_prod = 60; step();
    in_valid = 0; rst_n = 0; step(); rst_n = 1;
    total++; if ({in_ready, out_valid, out_ovf, busy} !== 4'b0 || out_sum !== 24'd0) begin bad++; $display("FAIL midreset got flags=%b sum=%0d want 0000/0", {in_ready, out_valid, out_ovf, busy}, out_sum); end
    start = 1; len = 1; step(); start = 0;
    in_valid = 1; in_prod = 7; step(); in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_sum !== 24'd7 || out_ovf !== 1'b0) begin bad++; $display("FAIL midreset_rerun got v=%b sum=%0d ovf=%b want 1/7/0", out_valid, out_sum, out_ovf); end
    out_ready = 1; step(); out_ready = 0;
  endtask
  task automatic test_ignored_start();
    start = 1; len = 2; step();
    len = 9;
    in_valid = 1; in_prod = 5; step();
    in_prod = 6; step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_sum !== 24'd11) begin bad++; $display("FAIL ign_done got v=%b sum=%0d want 1/11", out_valid, out_sum); end
    step();
    total++; if (out_valid !== 1'b1 || out_sum !== 24'd11) begin bad++; $display("FAIL ign_hold got v=%b sum=%0d want 1/11", out_valid, out_sum); end
    start = 0; out_ready = 1; step(); out_ready = 0;
    step();
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL ign_idle got busy=%b r=%b want 0/0", busy, in_ready); end
  endtask
  task automatic test_back_to_back();
    start = 1; len = 1; step(); start = 0;
    in_valid = 1; in_prod = 3; step(); in_valid = 0;
    out_ready = 1; step(); out_ready = 0;
    start = 1; len = 1; step(); start = 0;
    total++; if (in_ready !== 1'b1 || out_sum !== 24'd0) begin bad++; $display("FAIL b2b_restart got r=%b sum=%0d want 1/0", in_ready, out_sum); end
    in_valid = 1; in_prod = 9; step(); in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_sum !== 24'd9) begin bad++; $display("FAIL b2b_sum got v=%b sum=%0d want 1/9", out_valid, out_sum); end
    out_ready = 1; step(); out_ready = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_zero();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
